axi_error_slave: RTL and testbench
==================================

AXI_ERROR_SLAVE -- requirements
Module: axi_error_slave

Interface
REQ-001 Parameter RESP, default 2'b11 (DECERR), is the response code returned on every B and R beat.
REQ-002 Parameter DATA_VALUE, default 0, is the value driven on r_data for every read beat.
REQ-003 clk  input  1  clock for all logic.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 master  axi_channel.slave  interface-defined widths  AXI port terminated by this block; widths of id/addr/data/user come from the interface instance.

Function
REQ-006 The block SHALL terminate the AXI port completely: every AW, W and AR is accepted, and every burst receives protocol-correct responses carrying RESP.
REQ-007 The write path and read path SHALL be independent; each holds at most one outstanding transaction.
REQ-008 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP.
REQ-009 In W_IDLE: aw_ready=1, w_ready=0, b_valid=0; on aw_valid&&aw_ready, latch aw_id and go to W_DATA.
REQ-010 In W_DATA: aw_ready=0, w_ready=1; write data/strb/user are discarded; on w_valid&&w_ready&&w_last, go to W_RESP; beats without w_last stay in W_DATA.
REQ-011 The block SHALL NOT check the W beat count against aw_len; only w_last terminates the burst.
REQ-012 In W_RESP: b_valid=1, b_id=latched id, b_resp=RESP, b_user=0; on b_ready, go to W_IDLE; b_valid and b_id SHALL stay stable until the handshake.
REQ-013 W beats presented before their AW SHALL stall (w_ready=0 in W_IDLE) and never be consumed.
REQ-014 Read FSM states SHALL be R_IDLE and R_DATA.
REQ-015 In R_IDLE: ar_ready=1, r_valid=0; on ar_valid&&ar_ready, latch ar_id, load beat counter=ar_len (8 bits), go to R_DATA.
REQ-016 In R_DATA: ar_ready=0, r_valid=1, r_id=latched id, r_data=DATA_VALUE, r_resp=RESP, r_user=0, r_last=(counter==0).
REQ-017 On each r_valid&&r_ready in R_DATA: if counter==0 go to R_IDLE, else decrement counter.
REQ-018 Each read burst SHALL produce exactly ar_len+1 beats; ar_len=255 yields 256 beats with no wrap.
REQ-019 Latency: first r_valid the cycle after the AR handshake; b_valid the cycle after the w_last handshake; the next aw_ready/ar_ready the cycle after the final B/R handshake.
REQ-020 The same-cycle AR and AW handshakes, and simultaneous activity on both paths, SHALL proceed with no interaction.
REQ-021 ar_addr, aw_addr, size, burst, lock, cache, prot, qos, region and user inputs SHALL be ignored.
REQ-022 All outputs SHALL be driven from registered state only, with no combinational path from any input to any output.

Reset
REQ-023 On rstn low, asynchronously: both FSMs go to IDLE; counter, latched ids =0; outputs aw_ready=0, ar_ready=0, w_ready=0, b_valid=0, r_valid=0, r_last=0, b_id=0, r_id=0.
REQ-024 aw_ready and ar_ready SHALL assert in the first clock after rstn deasserts, not during reset.
REQ-025 Reset asserted mid-burst SHALL abandon the burst; after release, the block accepts a new AW/AR with no residual beats or responses.

Verification
REQ-026 AW(id=3, len=0) then W(last=1) -> B(id=3, resp=2'b11) one cycle after the W handshake; aw_ready returns the cycle after B handshake.
REQ-027 AR(id=5, len=3) with r_ready=1 -> 4 R beats, id=5, data=0, resp=2'b11, r_last only on 4th; ar_ready low throughout.
REQ-028 AR(len=255) with random r_ready stalls -> exactly 256 beats; r_id/r_last stable while stalled.
REQ-029 W(last=1) driven 5 cycles before AW(id=1) -> w_ready=0 until AW accepted; one B(id=1) results.
REQ-030 Concurrent AW(id=2, 4 W beats) and AR(id=7, len=1) in the same cycle, b_ready held low 10 cycles -> R burst completes unaffected; B(id=2) held until b_ready.
REQ-031 rstn pulsed low during beat 2 of AR(len=7) -> r_valid drops immediately; new AR(id=4, len=0) after release -> a single beat with r_last=1.

Source files
------------

// File: rtl/axi_error_slave.sv
// AXI error slave: accepts every AW/W/AR and answers each burst with response code RESP.
// Latency: first R beat / B response one cycle after the AR / last-W handshake; readies re-arm one cycle after the final R / B handshake.
// Backpressure: one outstanding burst per path; W is stalled until its AW is taken, and B/R beats are held stable until ready.
//
// Ports:
//   clk, rstn                  clock and asynchronous active-low reset
//   aw_* / w_* / b_*           write address, write data and write response channels
//   ar_* / r_*                 read address and read data channels
//   Address, size, burst, lock, cache, prot, qos, region, user and write data/strobe inputs are accepted and ignored.
module axi_error_slave #(
    parameter int                ID_W       = 4,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 64,
    parameter int                USER_W     = 1,
    parameter logic [1:0]        RESP       = 2'b11,
    parameter logic [DATA_W-1:0] DATA_VALUE = '0
) (
    input  logic                clk,
    input  logic                rstn,
    // write address
    input  logic                aw_valid,
    output logic                aw_ready,
    input  logic [ID_W-1:0]     aw_id,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic [7:0]          aw_len,
    input  logic [2:0]          aw_size,
    input  logic [1:0]          aw_burst,
    input  logic                aw_lock,
    input  logic [3:0]          aw_cache,
    input  logic [2:0]          aw_prot,
    input  logic [3:0]          aw_qos,
    input  logic [3:0]          aw_region,
    input  logic [USER_W-1:0]   aw_user,
    // write data
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_last,
    input  logic [USER_W-1:0]   w_user,
    // write response
    output logic                b_valid,
    input  logic                b_ready,
    output logic [ID_W-1:0]     b_id,
    output logic [1:0]          b_resp,
    output logic [USER_W-1:0]   b_user,
    // read address
    input  logic                ar_valid,
    output logic                ar_ready,
    input  logic [ID_W-1:0]     ar_id,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic [7:0]          ar_len,
    input  logic [2:0]          ar_size,
    input  logic [1:0]          ar_burst,
    input  logic                ar_lock,
    input  logic [3:0]          ar_cache,
    input  logic [2:0]          ar_prot,
    input  logic [3:0]          ar_qos,
    input  logic [3:0]          ar_region,
    input  logic [USER_W-1:0]   ar_user,
    // read data
    output logic                r_valid,
    input  logic                r_ready,
    output logic [ID_W-1:0]     r_id,
    output logic [DATA_W-1:0]   r_data,
    output logic [1:0]          r_resp,
    output logic                r_last,
    output logic [USER_W-1:0]   r_user
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    w_state_t        w_state, w_state_nxt;
    r_state_t        r_state, r_state_nxt;
    logic [ID_W-1:0] aw_id_q, aw_id_nxt;
    logic [ID_W-1:0] ar_id_q, ar_id_nxt;
    logic [7:0]      beat_cnt, beat_cnt_nxt;

    // Goes high on the first clock edge after reset release; keeps both
    // address readies low while reset is asserted even though the FSMs idle.
    logic            live;

    // Everything the block deliberately ignores is folded here.
    logic unused_inputs;
    assign unused_inputs = ^{aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
                             aw_prot, aw_qos, aw_region, aw_user,
                             w_data, w_strb, w_user,
                             ar_addr, ar_size, ar_burst, ar_lock, ar_cache,
                             ar_prot, ar_qos, ar_region, ar_user};

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live     <= 1'b0;
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            aw_id_q  <= '0;
            ar_id_q  <= '0;
            beat_cnt <= '0;
        end else begin
            live     <= 1'b1;
            w_state  <= w_state_nxt;
            r_state  <= r_state_nxt;
            aw_id_q  <= aw_id_nxt;
            ar_id_q  <= ar_id_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign aw_ready = live && (w_state == W_IDLE);
    assign w_ready  = (w_state == W_DATA);
    assign b_valid  = (w_state == W_RESP);
    assign b_id     = aw_id_q;
    assign b_resp   = RESP;
    assign b_user   = '0;

    assign ar_ready = live && (r_state == R_IDLE);
    assign r_valid  = (r_state == R_DATA);
    assign r_id     = ar_id_q;
    assign r_data   = DATA_VALUE;
    assign r_resp   = RESP;
    assign r_last   = (r_state == R_DATA) && (beat_cnt == 8'd0);
    assign r_user   = '0;

    // ------------------------------------------------------------------
    // Write FSM next state. Beat count is never compared with aw_len:
    // only w_last closes the burst.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = w_state;
        aw_id_nxt   = aw_id_q;
        case (w_state)
            W_IDLE: begin
                if (aw_valid && aw_ready) begin
                    aw_id_nxt   = aw_id;
                    w_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                if (w_valid && w_last) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (b_ready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read FSM next state. beat_cnt holds the beats remaining after the
    // one currently presented, so len=255 runs 256 beats without wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        r_state_nxt  = r_state;
        ar_id_nxt    = ar_id_q;
        beat_cnt_nxt = beat_cnt;
        case (r_state)
            R_IDLE: begin
                if (ar_valid && ar_ready) begin
                    ar_id_nxt    = ar_id;
                    beat_cnt_nxt = ar_len;
                    r_state_nxt  = R_DATA;
                end
            end
            R_DATA: begin
                if (r_ready) begin
                    if (beat_cnt == 8'd0) begin
                        r_state_nxt = R_IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt - 8'd1;
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_error_slave.sv
module tb_axi_error_slave;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int USER_W = 1;
    localparam logic [1:0] EXP_RESP = 2'b11;

    logic                clk;
    logic                rstn;
    logic                aw_valid, aw_ready;
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_qos;
    logic [3:0]          aw_region;
    logic [USER_W-1:0]   aw_user;
    logic                w_valid, w_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic [USER_W-1:0]   w_user;
    logic                b_valid, b_ready;
    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;
    logic                ar_valid, ar_ready;
    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic [3:0]          ar_qos;
    logic [3:0]          ar_region;
    logic [USER_W-1:0]   ar_user;
    logic                r_valid, r_ready;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [USER_W-1:0]   r_user;

    axi_error_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .USER_W(USER_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_lock(aw_lock),
        .aw_cache(aw_cache), .aw_prot(aw_prot), .aw_qos(aw_qos), .aw_region(aw_region),
        .aw_user(aw_user),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .w_last(w_last), .w_user(w_user),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_lock(ar_lock),
        .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_qos(ar_qos), .ar_region(ar_region),
        .ar_user(ar_user),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last), .r_user(r_user)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard / reference model (transaction level)
    // ------------------------------------------------------------------
    typedef struct {
        logic [ID_W-1:0] id;
        int              len;
    } rd_t;

    logic [ID_W-1:0] aw_q[$];   // accepted AWs not yet answered by B
    rd_t             ar_q[$];   // accepted ARs not yet fully returned
    int              data_done; // bursts whose w_last was taken, B still owed
    int              beats;     // beats returned so far for ar_q[0]
    int              r_hs_total;
    int              n_chk;
    int              n_fail;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        aw_q.delete();
        ar_q.delete();
        data_done = 0;
        beats     = 0;
    endtask

    // Compare outputs with the model, apply this cycle's handshakes to the
    // model, then advance to 1 time unit after the next rising edge.
    task automatic tick();
        rd_t e;
        if (rstn) begin
            chk1("m_aw_ready", aw_ready, aw_q.size() == 0);
            chk1("m_w_ready",  w_ready,  aw_q.size() > data_done);
            chk1("m_b_valid",  b_valid,  data_done > 0);
            if (data_done > 0 && aw_q.size() > 0) begin
                chkv("m_b_id",   64'(b_id),   64'(aw_q[0]));
                chkv("m_b_resp", 64'(b_resp), 64'(EXP_RESP));
                chkv("m_b_user", 64'(b_user), 64'd0);
            end
            chk1("m_ar_ready", ar_ready, ar_q.size() == 0);
            chk1("m_r_valid",  r_valid,  ar_q.size() > 0);
            if (ar_q.size() > 0) begin
                chkv("m_r_id",   64'(r_id),   64'(ar_q[0].id));
                chk1("m_r_last", r_last,      beats == ar_q[0].len);
                chkv("m_r_data", r_data,      64'd0);
                chkv("m_r_resp", 64'(r_resp), 64'(EXP_RESP));
                chkv("m_r_user", 64'(r_user), 64'd0);
            end
            if (b_valid && b_ready && aw_q.size() > 0 && data_done > 0) begin
                void'(aw_q.pop_front());
                data_done--;
            end
            if (w_valid && w_ready && w_last) data_done++;
            if (aw_valid && aw_ready) aw_q.push_back(aw_id);
            if (r_valid && r_ready && ar_q.size() > 0) begin
                r_hs_total++;
                beats++;
                if (beats > ar_q[0].len) begin
                    void'(ar_q.pop_front());
                    beats = 0;
                end
            end
            if (ar_valid && ar_ready) begin
                e.id  = ar_id;
                e.len = int'(ar_len);
                ar_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        aw_valid = 0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        aw_lock = 0; aw_cache = '0; aw_prot = '0; aw_qos = '0; aw_region = '0; aw_user = '0;
        w_valid = 0; w_data = '0; w_strb = '0; w_last = 0; w_user = '0;
        b_ready = 0;
        ar_valid = 0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
        ar_lock = 0; ar_cache = '0; ar_prot = '0; ar_qos = '0; ar_region = '0; ar_user = '0;
        r_ready = 0;
    endtask

    // Asserts reset at the current point (possibly mid-burst), checks the
    // reset values, releases it and steps one edge so readies come up.
    task automatic do_reset();
        set_idle();
        rstn = 0;
        #1;
        chk1("rst_aw_ready", aw_ready, 1'b0);
        chk1("rst_ar_ready", ar_ready, 1'b0);
        chk1("rst_w_ready",  w_ready,  1'b0);
        chk1("rst_b_valid",  b_valid,  1'b0);
        chk1("rst_r_valid",  r_valid,  1'b0);
        chk1("rst_r_last",   r_last,   1'b0);
        chkv("rst_b_id",     64'(b_id), 64'd0);
        chkv("rst_r_id",     64'(r_id), 64'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_hold_aw_ready", aw_ready, 1'b0);
        chk1("rst_hold_ar_ready", ar_ready, 1'b0);
        rstn = 1;
        #1;
        chk1("rel_aw_ready_early", aw_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("rel_aw_ready", aw_ready, 1'b1);
        chk1("rel_ar_ready", ar_ready, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs for one cycle and the outputs expected
    // in that same cycle (ids only compared while the matching valid is up)
    // ------------------------------------------------------------------
    typedef struct {
        logic       aw_v; logic [3:0] aw_i; logic w_v; logic w_l; logic b_r;
        logic       ar_v; logic [3:0] ar_i; logic [7:0] ar_l; logic r_r;
        logic       e_awr; logic e_wr; logic e_bv; logic [3:0] e_bid;
        logic       e_arr; logic e_rv; logic [3:0] e_rid; logic e_rl;
    } vec_t;

    vec_t vt[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   got;
        logic stalled;
        logic [ID_W-1:0] sid;
        logic sl;
        n_chk = 0; n_fail = 0; r_hs_total = 0;
        clear_model();
        set_idle();
        rstn = 1;
        #2;
        do_reset();

        //      aw_v aw_i w_v w_l b_r ar_v ar_i ar_l r_r | awr wr bv bid arr rv rid rl
        vt[0]  = '{1, 3, 0, 0, 0, 1, 5, 3, 1,  1, 0, 0, 0, 1, 0, 0, 0};
        vt[1]  = '{0, 0, 1, 1, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1, 5, 0};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 3, 0, 1, 5, 0};
        vt[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 1, 3, 0, 1, 5, 0};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 5, 1};
        vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 6; i <= 10; i++)
            vt[i] = '{0, 0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0};
        vt[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0};
        vt[12] = '{0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 0, 0};
        vt[13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0, 0};
        vt[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0};
        vt[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            aw_valid = vt[i].aw_v; aw_id = vt[i].aw_i; w_valid = vt[i].w_v; w_last = vt[i].w_l;
            b_ready = vt[i].b_r; ar_valid = vt[i].ar_v; ar_id = vt[i].ar_i; ar_len = vt[i].ar_l;
            r_ready = vt[i].r_r;
            chk1($sformatf("vec%0d_aw_ready", i), aw_ready, vt[i].e_awr);
            chk1($sformatf("vec%0d_w_ready", i),  w_ready,  vt[i].e_wr);
            chk1($sformatf("vec%0d_b_valid", i),  b_valid,  vt[i].e_bv);
            chk1($sformatf("vec%0d_ar_ready", i), ar_ready, vt[i].e_arr);
            chk1($sformatf("vec%0d_r_valid", i),  r_valid,  vt[i].e_rv);
            chk1($sformatf("vec%0d_r_last", i),   r_last,   vt[i].e_rl);
            if (vt[i].e_bv) chkv($sformatf("vec%0d_b_id", i), 64'(b_id), 64'(vt[i].e_bid));
            if (vt[i].e_rv) chkv($sformatf("vec%0d_r_id", i), 64'(r_id), 64'(vt[i].e_rid));
            tick();
        end
        set_idle();

        // Concurrent AW(id=2, 4 beats) and AR(id=7, len=1); B held off 11 cycles.
        aw_valid = 1; aw_id = 4'd2; ar_valid = 1; ar_id = 4'd7; ar_len = 8'd1; r_ready = 1;
        got = r_hs_total;
        tick();
        aw_valid = 0; ar_valid = 0;
        for (int i = 0; i < 4; i++) begin
            w_valid = 1; w_last = (i == 3);
            tick();
        end
        w_valid = 0; w_last = 0;
        repeat (6) tick();
        chkv("conc_r_beats", 64'(r_hs_total - got), 64'd2);
        chk1("conc_b_held", b_valid, 1'b1);
        chkv("conc_b_id", 64'(b_id), 64'd2);
        chk1("conc_ar_ready", ar_ready, 1'b1);
        b_ready = 1;
        tick();
        b_ready = 0;
        chk1("conc_b_done", b_valid, 1'b0);
        chk1("conc_aw_ready", aw_ready, 1'b1);

        // 256-beat read with random r_ready stalls.
        ar_valid = 1; ar_id = 4'd9; ar_len = 8'd255;
        tick();
        ar_valid = 0;
        got = 0; stalled = 0; sid = '0; sl = 0;
        for (int c = 0; c < 3000; c++) begin
            if (ar_ready) break;
            if (stalled) begin
                chkv("stall_r_id", 64'(r_id), 64'(sid));
                chk1("stall_r_last", r_last, sl);
            end
            r_ready = 1'($urandom % 2);
            stalled = r_valid && !r_ready;
            sid = r_id; sl = r_last;
            if (r_valid && r_ready) got++;
            tick();
        end
        r_ready = 0;
        chkv("len255_beats", 64'(got), 64'd256);
        chk1("len255_done", ar_ready, 1'b1);

        // Reset during beat 2 of an 8-beat read, then a single-beat read.
        ar_valid = 1; ar_id = 4'd6; ar_len = 8'd7; r_ready = 1;
        tick();
        ar_valid = 0;
        tick();
        tick();
        chk1("midrst_in_burst", r_valid, 1'b1);
        do_reset();
        ar_valid = 1; ar_id = 4'd4; ar_len = 8'd0; r_ready = 1;
        tick();
        ar_valid = 0;
        chk1("post_rst_r_valid", r_valid, 1'b1);
        chk1("post_rst_r_last", r_last, 1'b1);
        chkv("post_rst_r_id", 64'(r_id), 64'd4);
        tick();
        r_ready = 0;
        chk1("post_rst_single", r_valid, 1'b0);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            aw_valid  = ($urandom % 3) == 0;
            aw_id     = ID_W'($urandom);
            aw_len    = 8'($urandom);
            aw_addr   = $urandom;
            aw_prot   = 3'($urandom);
            w_valid   = 1'($urandom % 2);
            w_last    = ($urandom % 3) == 0;
            w_data    = {$urandom, $urandom};
            w_strb    = 8'($urandom);
            b_ready   = 1'($urandom % 2);
            ar_valid  = ($urandom % 3) == 0;
            ar_id     = ID_W'($urandom);
            ar_len    = (($urandom % 8) == 0) ? 8'($urandom) : 8'($urandom % 4);
            ar_addr   = $urandom;
            ar_cache  = 4'($urandom);
            r_ready   = 1'($urandom % 2);
            tick();
        end

        // Drain outstanding traffic with a bounded wait.
        set_idle();
        b_ready = 1; r_ready = 1; w_valid = 1; w_last = 1;
        for (int c = 0; c < 600; c++) begin
            if (aw_q.size() == 0 && ar_q.size() == 0) break;
            tick();
        end
        set_idle();
        chk1("drain_write", aw_q.size() == 0, 1'b1);
        chk1("drain_read", ar_q.size() == 0, 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
